// File: rtl/bus_pkg.sv
// Shared definitions for the memory-bus responder: FSM states, line geometry and
// the line/beat to backing-store word index helpers.
package bus_pkg;

  localparam int unsigned BUS_WRITE_BIT = 12;
  localparam int unsigned LINE_BYTES    = 64;
  localparam int unsigned WORD_BYTES    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLat,
    StRdBeat,
    StWrBeat
  } bus_state_e;

  // Word index of the first word of the line containing addr.
  function automatic logic [63:0] line_word(input logic [63:0] addr);
    logic [63:0] base;
    base = addr & ~64'(LINE_BYTES - 1);
    return base >> $clog2(WORD_BYTES);
  endfunction

  // Caller truncates to the store address width, which gives the wrap-around.
  function automatic logic [63:0] beat_index(input logic [63:0] base_word,
                                             input logic [63:0] beat);
    return base_word + beat;
  endfunction

endpackage

// File: rtl/mem_store_1rw.sv
// Single-port synchronous RAM with registered read data; contents survive reset.
module mem_store_1rw #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 65536,
  parameter int unsigned AW    = 16
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Main-memory model at the responder end of the shared cache/TLB bus: one line
// transaction at a time, 8-beat reads after a fixed latency, 8-beat writes.
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned MEM_WORDS      = 65536,
  parameter int unsigned READ_LATENCY   = 4,
  parameter int unsigned BEATS_PER_LINE = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned BW = $clog2(BEATS_PER_LINE);
  localparam int unsigned LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_LINE - 1);
  localparam logic [LW-1:0] LAT_INIT  = LW'(READ_LATENCY - 1);

  bus_state_e               state_q;
  logic [AW-1:0]            base_q;
  logic [BW-1:0]            beat_q;
  logic [LW-1:0]            lat_q;
  logic [BUS_TAG_WIDTH-1:0] tag_q;
  logic                     reqack_q;
  logic                     respcyc_q;
  logic [BUS_TAG_WIDTH-1:0] resptag_q;

  logic [63:0]               req_addr;
  logic                      mem_we;
  logic [BW-1:0]             mem_beat;
  logic [AW-1:0]             mem_addr;
  logic [BUS_DATA_WIDTH-1:0] mem_rdata;

  assign req_addr = 64'(bus_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      base_q    <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      tag_q     <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resptag_q <= '0;
    end else begin
      reqack_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus_reqcyc) begin
            reqack_q <= 1'b1;
            base_q   <= AW'(line_word(req_addr));
            tag_q    <= bus_reqtag;
            beat_q   <= '0;
            if (bus_reqtag[BUS_WRITE_BIT]) begin
              state_q <= StWrBeat;
            end else begin
              state_q <= StLat;
              lat_q   <= LAT_INIT;
            end
          end
        end
        StLat: begin
          if (lat_q == '0) begin
            state_q   <= StRdBeat;
            respcyc_q <= 1'b1;
            resptag_q <= tag_q;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        StRdBeat: begin
          if (bus_respack) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              state_q   <= StIdle;
              respcyc_q <= 1'b0;
              resptag_q <= '0;
            end
          end
        end
        StWrBeat: begin
          if (bus_reqcyc) begin
            reqack_q <= 1'b1;
            beat_q   <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The store read is registered, so address the beat that will be on the bus
  // after this edge: the next one when the current beat is being accepted.
  always_comb begin
    mem_we   = 1'b0;
    mem_beat = beat_q;
    case (state_q)
      StRdBeat: begin
        if (bus_respack) begin
          mem_beat = beat_q + 1'b1;
        end
      end
      StWrBeat: mem_we = bus_reqcyc;
      default: ;
    endcase
    mem_addr = AW'(beat_index(64'(base_q), 64'(mem_beat)));
  end

  mem_store_1rw #(
    .WIDTH (BUS_DATA_WIDTH),
    .DEPTH (MEM_WORDS),
    .AW    (AW)
  ) u_store (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (bus_req),
    .rdata_o (mem_rdata)
  );

  assign bus_reqack  = reqack_q;
  assign bus_respcyc = respcyc_q;
  // Gated by respcyc_q so the data output clears with the asynchronous reset.
  assign bus_resp    = respcyc_q ? mem_rdata : '0;
  assign bus_resptag = resptag_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: line writes, a table of line reads, and
// hand-written busy-request and mid-read reset sequences.
module tb_bus_mem_responder;

  localparam int unsigned DW  = 64;
  localparam int unsigned TW  = 13;
  localparam int unsigned MW  = 65536;
  localparam int unsigned RL  = 4;
  localparam int unsigned BPL = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bus_reqcyc = 1'b0;
  logic [DW-1:0] bus_req = '0;
  logic [TW-1:0] bus_reqtag = '0;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] addr;
    logic [12:0] tag;
    int          stall_beat;
    int          stall_len;
    logic [63:0] exp0;
    string       name;
  } rd_vec_t;

  rd_vec_t vecs[5];

  bus_mem_responder #(
    .BUS_DATA_WIDTH (DW),
    .BUS_TAG_WIDTH  (TW),
    .MEM_WORDS      (MW),
    .READ_LATENCY   (RL),
    .BEATS_PER_LINE (BPL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an address cycle for one edge and checks the ack; leaves reqcyc high.
  task automatic issue(input logic [63:0] addr, input logic [12:0] tag, input string nm);
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = tag;
    step();
    chk($sformatf("%s_ack", nm), 64'(bus_reqack), 64'(1));
  endtask

  // Called right after the address-ack edge; walks the read through its beats.
  task automatic finish_read(input logic [12:0] tag, input logic [63:0] exp0,
                             input int stall_beat, input int stall_len,
                             input int stop_at, input string nm);
    int lat = 0;
    bit seen_ack = 1'b0;
    while (!bus_respcyc && lat < 20) begin
      step();
      lat++;
      if (bus_reqack) seen_ack = 1'b1;
    end
    chk($sformatf("%s_latency", nm), 64'(lat), 64'(RL));
    for (int b = 0; b < BPL; b++) begin
      chk($sformatf("%s_valid%0d", nm, b), 64'(bus_respcyc), 64'(1));
      chk($sformatf("%s_beat%0d", nm, b), bus_resp, exp0 + 64'(b));
      chk($sformatf("%s_tag%0d", nm, b), 64'(bus_resptag), 64'(tag));
      if (b == stop_at) return;
      if (b == stall_beat) begin
        for (int s = 0; s < stall_len; s++) begin
          bus_respack = 1'b0;
          step();
          if (bus_reqack) seen_ack = 1'b1;
          chk($sformatf("%s_hold%0d_%0d", nm, b, s), bus_resp, exp0 + 64'(b));
          chk($sformatf("%s_holdv%0d_%0d", nm, b, s), 64'(bus_respcyc), 64'(1));
        end
      end
      bus_respack = 1'b1;
      step();
      bus_respack = 1'b0;
      if (bus_reqack) seen_ack = 1'b1;
    end
    chk($sformatf("%s_end", nm), 64'(bus_respcyc), 64'(0));
    chk($sformatf("%s_noack", nm), 64'(seen_ack), 64'(0));
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [12:0] tag,
                          input logic [63:0] data0, input int stall_after,
                          input int stall_len, input string nm);
    int acks = 0;
    bit saw_resp = 1'b0;
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = tag;
    step();
    if (bus_reqack) acks++;
    if (bus_respcyc) saw_resp = 1'b1;
    for (int b = 0; b < BPL; b++) begin
      bus_reqcyc = 1'b1;
      bus_req    = data0 + 64'(b);
      step();
      if (bus_reqack) acks++;
      if (bus_respcyc) saw_resp = 1'b1;
      if (b == stall_after) begin
        bus_reqcyc = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          step();
          if (bus_reqack) acks++;
          if (bus_respcyc) saw_resp = 1'b1;
        end
      end
    end
    bus_reqcyc = 1'b0;
    bus_req    = '0;
    for (int s = 0; s < 2; s++) begin
      step();
      if (bus_reqack) acks++;
      if (bus_respcyc) saw_resp = 1'b1;
    end
    chk($sformatf("%s_acks", nm), 64'(acks), 64'(BPL + 1));
    chk($sformatf("%s_noresp", nm), 64'(saw_resp), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64'h205,   13'h0011, -1, 0, 64'h1000, "rd_lat"};
    vecs[1] = '{64'h205,   13'h0011,  2, 3, 64'h1000, "rd_stall"};
    vecs[2] = '{64'h80200, 13'h0022, -1, 0, 64'h1000, "rd_wrap"};
    vecs[3] = '{64'h1C0,   13'h0033, -1, 0, 64'h00A0, "rd_after_wr"};
    vecs[4] = '{64'h23F,   13'h0FFF,  7, 2, 64'h1000, "rd_hi_off"};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_reqack", 64'(bus_reqack), 64'(0));
    chk("rst_respcyc", 64'(bus_respcyc), 64'(0));
    chk("rst_resp", bus_resp, 64'(0));
    chk("rst_resptag", 64'(bus_resptag), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    step();

    do_write(64'h200, 13'h1001, 64'h1000, -1, 0, "preload");
    do_write(64'h1C0, 13'h1005, 64'h00A0, 3, 2, "wr_stall");

    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].addr, vecs[i].tag, vecs[i].name);
      bus_reqcyc = 1'b0;
      finish_read(vecs[i].tag, vecs[i].exp0, vecs[i].stall_beat, vecs[i].stall_len,
                  BPL, vecs[i].name);
    end

    // Second request held from the latency phase onward must wait for IDLE.
    issue(64'h200, 13'h0044, "busy_a");
    bus_req    = 64'h1C0;
    bus_reqtag = 13'h0055;
    finish_read(13'h0044, 64'h1000, -1, 0, BPL, "busy_a");
    chk("busy_idle_noack", 64'(bus_reqack), 64'(0));
    step();
    chk("busy_ack_next", 64'(bus_reqack), 64'(1));
    bus_reqcyc = 1'b0;
    finish_read(13'h0055, 64'h00A0, -1, 0, BPL, "busy_b");

    // Asynchronous reset while beat 4 is on the bus.
    issue(64'h200, 13'h0066, "rst_rd");
    bus_reqcyc = 1'b0;
    finish_read(13'h0066, 64'h1000, -1, 0, 4, "rst_rd");
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_respcyc", 64'(bus_respcyc), 64'(0));
    chk("midrst_resp", bus_resp, 64'(0));
    chk("midrst_resptag", 64'(bus_resptag), 64'(0));
    chk("midrst_reqack", 64'(bus_reqack), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    step();
    issue(64'h205, 13'h0077, "post_rst");
    bus_reqcyc = 1'b0;
    finish_read(13'h0077, 64'h1000, -1, 0, BPL, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
